// File: rtl/ras_ckpt.sv
// Checkpointed return-address stack: circular stack plus NUM_CKPT snapshots
// of {ptr, count, top} ordered by an age matrix for mispredict recovery.
module ras_ckpt #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned NUM_CKPT = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic                          pop,
    input  logic [ADDR_W-1:0]             push_addr,
    output logic [ADDR_W-1:0]             top_addr,
    output logic                          top_valid,
    output logic [$clog2(DEPTH):0]        count,
    input  logic                          ckpt_alloc,
    output logic [$clog2(NUM_CKPT)-1:0]   ckpt_tag,
    output logic                          ckpt_full,
    input  logic                          ckpt_free,
    input  logic [$clog2(NUM_CKPT)-1:0]   ckpt_free_tag,
    input  logic                          restore,
    input  logic [$clog2(NUM_CKPT)-1:0]   restore_tag
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned TAG_W = $clog2(NUM_CKPT);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] entry_q [DEPTH];
    logic [PTR_W-1:0]  ptr_q, ptr_d, ptr_m1;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [NUM_CKPT-1:0]                valid_q, valid_d;
    // age_q[i][j] set means slot i was allocated after slot j
    logic [NUM_CKPT-1:0][NUM_CKPT-1:0]  age_q, age_d;
    logic [PTR_W-1:0]  ck_ptr_q [NUM_CKPT];
    logic [CNT_W-1:0]  ck_cnt_q [NUM_CKPT];
    logic [ADDR_W-1:0] ck_top_q [NUM_CKPT];

    logic              wr_en;
    logic [PTR_W-1:0]  wr_idx;
    logic [ADDR_W-1:0] wr_data;
    logic              do_restore, do_alloc;

    assign ptr_m1 = ptr_q - PTR_W'(1);

    // Outputs are decoded purely from registered state
    always_comb begin
        top_valid = (cnt_q != '0);
        top_addr  = top_valid ? entry_q[ptr_m1] : '0;
        count     = cnt_q;
        ckpt_full = &valid_q;
        ckpt_tag  = '0;
        for (int k = NUM_CKPT - 1; k >= 0; k--) begin
            if (!valid_q[k]) ckpt_tag = TAG_W'(k);
        end
    end

    assign do_restore = restore && valid_q[restore_tag];
    assign do_alloc   = !restore && ckpt_alloc && !ckpt_full;

    // Stack pointer/count next state and the single entry write port
    always_comb begin
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_idx  = ptr_q;
        wr_data = push_addr;
        if (do_restore) begin
            ptr_d   = ck_ptr_q[restore_tag];
            cnt_d   = ck_cnt_q[restore_tag];
            wr_en   = 1'b1;
            wr_idx  = ck_ptr_q[restore_tag] - PTR_W'(1);
            wr_data = ck_top_q[restore_tag];
        end else if (!restore) begin
            if (push && pop && cnt_q != '0) begin
                wr_en  = 1'b1;
                wr_idx = ptr_m1;
            end else if (push) begin
                wr_en = 1'b1;
                ptr_d = ptr_q + PTR_W'(1);
                if (cnt_q != CNT_W'(DEPTH)) cnt_d = cnt_q + CNT_W'(1);
            end else if (pop && cnt_q != '0) begin
                ptr_d = ptr_m1;
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // Checkpoint valid bits and age matrix: squash, free, allocate, then scrub
    always_comb begin
        valid_d = valid_q;
        age_d   = age_q;
        if (do_restore) begin
            for (int k = 0; k < NUM_CKPT; k++) begin
                if (k == int'(restore_tag) || age_q[k][restore_tag]) valid_d[k] = 1'b0;
            end
        end
        if (ckpt_free) valid_d[ckpt_free_tag] = 1'b0;
        if (do_alloc) begin
            valid_d[ckpt_tag] = 1'b1;
            age_d[ckpt_tag]   = valid_q;
        end
        for (int k = 0; k < NUM_CKPT; k++) begin
            if (!valid_d[k]) begin
                age_d[k] = '0;
                for (int j = 0; j < NUM_CKPT; j++) age_d[j][k] = 1'b0;
            end
        end
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            cnt_q   <= '0;
            valid_q <= '0;
            age_q   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            age_q   <= age_d;
        end
    end

    // Stack entries and checkpoint payloads carry no reset
    always_ff @(posedge clk) begin
        if (!rst && wr_en) entry_q[wr_idx] <= wr_data;
        if (!rst && do_alloc) begin
            ck_ptr_q[ckpt_tag] <= ptr_q;
            ck_cnt_q[ckpt_tag] <= cnt_q;
            ck_top_q[ckpt_tag] <= top_addr;
        end
    end
endmodule

// File: tb/tb_ras_ckpt.sv
// Directed bench for ras_ckpt with immediate-assertion checks.
module tb_ras_ckpt;
    logic        clk = 1'b0;
    logic        rst, push, pop, ckpt_alloc, ckpt_free, restore;
    logic [31:0] push_addr, top_addr;
    logic        top_valid, ckpt_full;
    logic [4:0]  count;
    logic [1:0]  ckpt_tag, ckpt_free_tag, restore_tag;
    int          total = 0;
    int          bad = 0;

    ras_ckpt dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .push_addr(push_addr),
        .top_addr(top_addr), .top_valid(top_valid), .count(count),
        .ckpt_alloc(ckpt_alloc), .ckpt_tag(ckpt_tag), .ckpt_full(ckpt_full),
        .ckpt_free(ckpt_free), .ckpt_free_tag(ckpt_free_tag),
        .restore(restore), .restore_tag(restore_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 0; push = 0; pop = 0; push_addr = '0; ckpt_alloc = 0;
        ckpt_free = 0; ckpt_free_tag = '0; restore = 0; restore_tag = '0;
    endtask

    // Apply current inputs for one edge, then return inputs to idle
    task automatic cyc();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_push(input logic [31:0] a);
        push = 1; push_addr = a; cyc();
    endtask

    task automatic do_pop();
        pop = 1; cyc();
    endtask

    task automatic do_rst();
        rst = 1; cyc();
    endtask

    initial begin
        idle();
        rst = 1;
        @(posedge clk); #1;
        cyc();
        chk("rst_count", 32'(count), 0);
        chk("rst_top_valid", 32'(top_valid), 0);
        chk("rst_top_addr", top_addr, 0);
        chk("rst_full", 32'(ckpt_full), 0);
        chk("rst_tag", 32'(ckpt_tag), 0);

        do_push(32'h100); do_push(32'h200); do_push(32'h300);
        chk("push3_count", 32'(count), 3);
        chk("push3_top", top_addr, 32'h300);
        do_pop();
        chk("pop_top", top_addr, 32'h200);
        chk("pop_count", 32'(count), 2);

        push = 1; pop = 1; push_addr = 32'h500; cyc();
        chk("pp_top", top_addr, 32'h500);
        chk("pp_count", 32'(count), 2);

        do_rst();
        push = 1; pop = 1; push_addr = 32'h500; cyc();
        chk("pp_empty_count", 32'(count), 1);
        chk("pp_empty_top", top_addr, 32'h500);

        do_rst();
        for (int i = 1; i <= 18; i++) do_push(32'(i * 16));
        chk("ovf_count", 32'(count), 16);
        chk("ovf_top", top_addr, 32'h120);
        for (int i = 0; i < 15; i++) do_pop();
        chk("drain_last_top", top_addr, 32'h30);
        chk("drain_last_count", 32'(count), 1);
        do_pop();
        chk("drain_empty_valid", 32'(top_valid), 0);
        chk("drain_empty_top", top_addr, 0);
        do_pop();
        chk("underflow_count", 32'(count), 0);

        // Single checkpoint and restore after the top entry was overwritten
        do_push(32'hA0);
        chk("ck_tag0", 32'(ckpt_tag), 0);
        ckpt_alloc = 1; cyc();
        chk("ck_tag_after", 32'(ckpt_tag), 1);
        do_pop(); do_push(32'hB0); do_push(32'hC0);
        chk("ck_pre_top", top_addr, 32'hC0);
        chk("ck_pre_count", 32'(count), 2);
        restore = 1; restore_tag = 0; cyc();
        chk("rs_count", 32'(count), 1);
        chk("rs_top", top_addr, 32'hA0);
        chk("rs_tag", 32'(ckpt_tag), 0);
        chk("rs_full", 32'(ckpt_full), 0);

        // Fill all slots, overflow alloc, then squash younger ones
        for (int i = 0; i < 4; i++) begin
            chk("fill_tag", 32'(ckpt_tag), 32'(i));
            ckpt_alloc = 1; cyc();
        end
        chk("fill_full", 32'(ckpt_full), 1);
        ckpt_alloc = 1; cyc();
        chk("fill_extra_full", 32'(ckpt_full), 1);
        restore = 1; restore_tag = 1; cyc();
        chk("sq_full", 32'(ckpt_full), 0);
        chk("sq_tag", 32'(ckpt_tag), 1);
        chk("sq_count", 32'(count), 1);

        // Restore wins over same-cycle push and alloc
        ckpt_alloc = 1; cyc();
        ckpt_alloc = 1; cyc();
        chk("re_tag3", 32'(ckpt_tag), 3);
        do_push(32'hD0);
        chk("re_pre_count", 32'(count), 2);
        restore = 1; restore_tag = 2; push = 1; push_addr = 32'hE0; ckpt_alloc = 1; cyc();
        chk("re_count", 32'(count), 1);
        chk("re_top", top_addr, 32'hA0);
        chk("re_tag", 32'(ckpt_tag), 2);

        // Free the oldest slot; younger slot 1 must survive
        ckpt_free = 1; ckpt_free_tag = 0; cyc();
        chk("free_tag", 32'(ckpt_tag), 0);
        restore = 1; restore_tag = 1; cyc();
        chk("free_rs_count", 32'(count), 1);
        chk("free_rs_tag", 32'(ckpt_tag), 0);
        ckpt_alloc = 1; cyc();
        chk("free_realloc_tag", 32'(ckpt_tag), 1);

        // Reset mid-sequence overrides everything
        do_push(32'hF0);
        rst = 1; push = 1; push_addr = 32'h77; ckpt_alloc = 1; restore = 1; restore_tag = 0; cyc();
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_valid", 32'(top_valid), 0);
        chk("mid_rst_top", top_addr, 0);
        chk("mid_rst_full", 32'(ckpt_full), 0);
        chk("mid_rst_tag", 32'(ckpt_tag), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ras_ckpt.md
Name: ras_ckpt

Overview:
Checkpointed return-address stack for the fetch/branch-predict stage. It supports configurable depth, address width and checkpoint count. A circular stack overwrites its oldest entry on overflow. Up to NUM_CKPT outstanding branch checkpoints are held; a mispredict restores the stack from its checkpoint and squashes all younger checkpoints in one cycle.

Parameters:
DEPTH, 16, stack entries; power of 2, >=2
ADDR_W, 32, return-address width
NUM_CKPT, 4, outstanding checkpoints; >=2
PTR_W, $clog2(DEPTH), derived, not overridable
TAG_W, $clog2(NUM_CKPT), derived, not overridable

Ports:
clk  in  1  clock
rst  in  1  reset; rst is synchronous, active-high; clock is clk
push  in  1  call predicted; push push_addr
pop  in  1  return predicted; pop top
push_addr  in  ADDR_W  return address to push
top_addr  out  ADDR_W  current top entry; 0 when empty
top_valid  out  1  stack non-empty (count != 0)
count  out  PTR_W+1  live entries, 0..DEPTH
ckpt_alloc  in  1  request checkpoint of current state
ckpt_tag  out  TAG_W  tag granted if ckpt_alloc this cycle
ckpt_full  out  1  no free checkpoint slot
ckpt_free  in  1  commit: release ckpt_free_tag
ckpt_free_tag  in  TAG_W  tag to release
restore  in  1  mispredict: restore from restore_tag
restore_tag  in  TAG_W  checkpoint to restore

Behaviour:
- State: entry[DEPTH], ptr (next write slot, mod DEPTH), count, ckpt slots {valid, ptr, count, top}, NUM_CKPT x NUM_CKPT age matrix.
- Reset, next edge with rst=1:
  - ptr=0, count=0, all ckpt valid=0, age matrix cleared.
  - Outputs then: top_valid=0, top_addr=0, count=0, ckpt_full=0, ckpt_tag=0.
  - Entry contents are don't-care.
  - rst overrides every other input, including mid-restore.
- Outputs are combinational from registered state.
  - top_addr = entry[ptr-1] when count>0, else 0.
  - ckpt_tag = lowest-index invalid slot.
  - ckpt_full = all slots valid.
- Stack update (only when restore=0), one-cycle latency:
  - Push only: entry[ptr]=push_addr; ptr+1; count=min(count+1, DEPTH). At count==DEPTH the oldest entry is overwritten and count stays DEPTH.
  - Pop only: if count>0, ptr-1 and count-1. If count==0, no state change; underflow is ignored.
  - Push and pop together (jalr call+return), count>0: entry[ptr-1]=push_addr; ptr and count unchanged.
  - Push and pop together, count==0: behaves as push only.
  - Wrap: ptr arithmetic is modulo DEPTH; ptr-1 at ptr=0 addresses DEPTH-1.
- Checkpoint alloc (only when restore=0 and ckpt_full=0):
  - Slot ckpt_tag captures {ptr, count, top_addr} as of the start of the cycle, i.e. excluding a same-cycle push/pop.
  - The slot is marked valid and younger than every currently valid slot.
  - ckpt_alloc while ckpt_full: ignored, no state change. Upstream stalls on ckpt_full.
- Restore (restore=1, slot restore_tag valid):
  - ptr, count come from the slot; entry[slot.ptr-1]=slot.top.
  - Same-cycle push/pop/alloc are ignored.
  - Slot restore_tag and all slots younger than it are invalidated; older slots are kept.
  - Restore of an invalid tag: no state change.
- Free: ckpt_free invalidates ckpt_free_tag and clears its age row/column.
  - Free of an invalid tag is a no-op.
  - Free and restore in the same cycle: both apply. A freed slot that would also be squashed is simply invalid.
  - A slot freed this cycle is not re-allocatable until the next cycle.
- Restored top entry reconstruction is exact only if at most one overwrite of entry[slot.ptr-1] occurred since the checkpoint. Deeper corruption is an accepted prediction loss, not an error.

Test Plan:
- Reset, then 3 pushes 0x100,0x200,0x300 -> count=3, top_addr=0x300; pop -> top_addr=0x200, count=2.
- DEPTH=16: 18 pushes of 0x10*i (i=1..18) -> count=16, top=0x120. 16 pops -> last valid top is 0x30, then top_valid=0. A further pop leaves count=0.
- Push+pop same cycle with top=0x200 and push_addr=0x500 -> top=0x500, count unchanged. On an empty stack -> count=1, top=0x500.
- Push 0xA0, alloc (tag 0), pop, push 0xB0, push 0xC0, restore tag 0 -> count=1, top=0xA0, slot 0 free, ckpt_full=0.
- Alloc tags 0,1,2,3 (ckpt_full=1) -> fifth alloc ignored. Restore tag 1 -> slots 1-3 free, slot 0 valid, next ckpt_tag=1.
- Same cycle: restore tag 2 while asserting push and ckpt_alloc -> push and alloc have no effect. With rst asserted mid-sequence -> all outputs return to reset values next cycle.
